// File: rtl/serial_port_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_port_if
// Brief    : Processor-side byte handshake between the CPU and serial_port.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_port_if;
    logic       rden_in;
    logic       wren_in;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_out;

    modport master (
        output rden_in, wren_in, data_in,
        input  data_out, valid_out, ready_out
    );

    modport slave (
        input  rden_in, wren_in, data_in,
        output data_out, valid_out, ready_out
    );
endinterface
`default_nettype wire

// File: rtl/serial_port.sv
`default_nettype none
// ============================================================================
// Module   : serial_port (+ serial_port_fifo)
// Brief    : FIFO-buffered 8N1 UART responder for the processor serial bus.
// Revision : 1.0 - initial release
// ============================================================================
module serial_port_fifo #(
    parameter int AW = 3
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       push,
    input  wire logic       pop,
    input  wire logic [7:0] wdata,
    output logic      [7:0] rdata,
    output logic            empty,
    output logic            full
);
    localparam int            c_depth      = 1 << AW;
    localparam logic [AW:0]   c_full_count = (AW + 1)'(c_depth);

    logic [7:0]    r_mem [c_depth];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == c_full_count);
    // Acceptance uses the pre-pop count, so a push into a full FIFO is refused
    // even when a pop happens in the same cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = empty ? 8'h00 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end
endmodule

module serial_port #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 3
) (
    input  wire logic  clk,
    input  wire logic  reset,
    serial_port_if.slave bus,
    input  wire logic  uart_rx,
    output logic       uart_tx,
    output logic       rx_overrun_out,
    output logic       rx_frame_err_out
);
    localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_bit_max  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_max = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ---------------- transmit path ----------------
    state_t             r_tx_state, w_tx_state_next;
    logic [c_cnt_w-1:0] r_tx_cnt,   w_tx_cnt_next;
    logic [2:0]         r_tx_idx,   w_tx_idx_next;
    logic [7:0]         r_tx_shift, w_tx_shift_next;
    logic               r_uart_tx;
    logic               w_tx_line;
    logic               w_tx_pop;
    logic [7:0]         w_tx_head;
    logic               w_tx_empty;
    logic               w_tx_full;

    serial_port_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.wren_in),
        .pop   (w_tx_pop),
        .wdata (bus.data_in),
        .rdata (w_tx_head),
        .empty (w_tx_empty),
        .full  (w_tx_full)
    );

    assign bus.ready_out = !w_tx_full;
    assign uart_tx       = r_uart_tx;

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt;
        w_tx_idx_next   = r_tx_idx;
        w_tx_shift_next = r_tx_shift;
        w_tx_pop        = 1'b0;
        w_tx_line       = 1'b1;
        case (r_tx_state)
            ST_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop        = 1'b1;
                    w_tx_shift_next = w_tx_head;
                    w_tx_cnt_next   = c_bit_max;
                    w_tx_state_next = ST_START;
                end
            end
            ST_START: begin
                w_tx_line = 1'b0;
                if (r_tx_cnt == '0) begin
                    w_tx_cnt_next   = c_bit_max;
                    w_tx_idx_next   = 3'd0;
                    w_tx_state_next = ST_DATA;
                end else begin
                    w_tx_cnt_next = r_tx_cnt - c_cnt_one;
                end
            end
            ST_DATA: begin
                w_tx_line = r_tx_shift[r_tx_idx];
                if (r_tx_cnt == '0) begin
                    w_tx_cnt_next = c_bit_max;
                    if (r_tx_idx == 3'd7) w_tx_state_next = ST_STOP;
                    else                  w_tx_idx_next   = r_tx_idx + 3'd1;
                end else begin
                    w_tx_cnt_next = r_tx_cnt - c_cnt_one;
                end
            end
            ST_STOP: begin
                // Last stop cycle doubles as the idle check: queued bytes
                // start immediately with no extra idle bit.
                if (r_tx_cnt == '0) begin
                    if (!w_tx_empty) begin
                        w_tx_pop        = 1'b1;
                        w_tx_shift_next = w_tx_head;
                        w_tx_cnt_next   = c_bit_max;
                        w_tx_state_next = ST_START;
                    end else begin
                        w_tx_state_next = ST_IDLE;
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt - c_cnt_one;
                end
            end
            default: w_tx_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_uart_tx  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_idx   <= w_tx_idx_next;
            r_tx_shift <= w_tx_shift_next;
            r_uart_tx  <= w_tx_line;
        end
    end

    // ---------------- receive path ----------------
    logic               r_sync1;
    logic               r_sync2;
    state_t             r_rx_state, w_rx_state_next;
    logic [c_cnt_w-1:0] r_rx_cnt,   w_rx_cnt_next;
    logic [2:0]         r_rx_idx,   w_rx_idx_next;
    logic [7:0]         r_rx_shift, w_rx_shift_next;
    logic               w_rx_push;
    logic               w_set_overrun;
    logic               w_set_frame_err;
    logic               w_rx_empty;
    logic               w_rx_full;
    logic               r_overrun;
    logic               r_frame_err;

    serial_port_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_rx_push),
        .pop   (bus.rden_in),
        .wdata (r_rx_shift),
        .rdata (bus.data_out),
        .empty (w_rx_empty),
        .full  (w_rx_full)
    );

    assign bus.valid_out    = !w_rx_empty;
    assign rx_overrun_out   = r_overrun;
    assign rx_frame_err_out = r_frame_err;

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_idx_next   = r_rx_idx;
        w_rx_shift_next = r_rx_shift;
        w_rx_push       = 1'b0;
        w_set_overrun   = 1'b0;
        w_set_frame_err = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                if (!r_sync2) begin
                    w_rx_cnt_next   = c_half_max;
                    w_rx_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_rx_cnt == '0) begin
                    if (r_sync2) begin
                        w_rx_state_next = ST_IDLE;
                    end else begin
                        w_rx_cnt_next   = c_bit_max;
                        w_rx_idx_next   = 3'd0;
                        w_rx_state_next = ST_DATA;
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt - c_cnt_one;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == '0) begin
                    w_rx_shift_next = {r_sync2, r_rx_shift[7:1]};
                    w_rx_cnt_next   = c_bit_max;
                    if (r_rx_idx == 3'd7) w_rx_state_next = ST_STOP;
                    else                  w_rx_idx_next   = r_rx_idx + 3'd1;
                end else begin
                    w_rx_cnt_next = r_rx_cnt - c_cnt_one;
                end
            end
            ST_STOP: begin
                // Leaving at the mid-stop sample lets the next start bit be
                // caught half a bit early.
                if (r_rx_cnt == '0) begin
                    w_rx_state_next = ST_IDLE;
                    if (!r_sync2)       w_set_frame_err = 1'b1;
                    else if (w_rx_full) w_set_overrun   = 1'b1;
                    else                w_rx_push       = 1'b1;
                end else begin
                    w_rx_cnt_next = r_rx_cnt - c_cnt_one;
                end
            end
            default: w_rx_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_state  <= ST_IDLE;
            r_rx_cnt    <= '0;
            r_rx_idx    <= '0;
            r_rx_shift  <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= uart_rx;
            r_sync2     <= r_sync1;
            r_rx_state  <= w_rx_state_next;
            r_rx_cnt    <= w_rx_cnt_next;
            r_rx_idx    <= w_rx_idx_next;
            r_rx_shift  <= w_rx_shift_next;
            r_overrun   <= r_overrun | w_set_overrun;
            r_frame_err <= r_frame_err | w_set_frame_err;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_serial_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_port
// Brief    : Directed self-checking bench for serial_port (8 clks/bit, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_port;
    logic clk = 1'b0;
    logic reset;
    logic uart_rx;
    logic uart_tx;
    logic rx_overrun_out;
    logic rx_frame_err_out;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic txq[$];
    logic valq[$];

    serial_port_if bus();

    serial_port #(.CLKS_PER_BIT(8), .FIFO_AW(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .uart_rx          (uart_rx),
        .uart_tx          (uart_tx),
        .rx_overrun_out   (rx_overrun_out),
        .rx_frame_err_out (rx_frame_err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and log the line and valid status.
    task automatic step();
        @(negedge clk);
        txq.push_back(uart_tx);
        valq.push_back(bus.valid_out);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] data);
        logic [9:0] bits;
        logic [7:0] s;
        bits = {1'b1, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 8; k++) s[k] = txq[base + b * 8 + k];
            check($sformatf("%s_bit%0d", tag, b), 32'(s), 32'({8{bits[b]}}));
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            uart_rx = bits[b];
            steps(8);
        end
        uart_rx = 1'b1;
    endtask

    task automatic count_high(input string tag, input int from, input int to);
        int ones;
        ones = 0;
        for (int i = from; i < to; i++) if (txq[i] === 1'b1) ones++;
        check(tag, 32'(ones), 32'(to - from));
    endtask

    initial begin
        reset       = 1'b1;
        uart_rx     = 1'b1;
        bus.rden_in = 1'b0;
        bus.wren_in = 1'b0;
        bus.data_in = 8'h00;
        steps(2);

        // Reset state
        check("rst_uart_tx",   32'(uart_tx),          32'd1);
        check("rst_valid",     32'(bus.valid_out),    32'd0);
        check("rst_ready",     32'(bus.ready_out),    32'd1);
        check("rst_data_out",  32'(bus.data_out),     32'd0);
        check("rst_overrun",   32'(rx_overrun_out),   32'd0);
        check("rst_frame_err", 32'(rx_frame_err_out), 32'd0);
        reset = 1'b0;
        steps(2);

        // TX single byte 0xA5: low from the second edge after the write
        txq.delete();
        bus.data_in = 8'hA5;
        bus.wren_in = 1'b1;
        step();
        bus.wren_in = 1'b0;
        steps(82);
        check("tx1_pre0", 32'(txq[0]), 32'd1);
        check("tx1_pre1", 32'(txq[1]), 32'd1);
        check_frame("tx1_a5", 2, 8'hA5);
        check("tx1_idle", 32'(txq[82]), 32'd1);

        // TX back-to-back 0x01..0x05, sixth write while full is dropped
        txq.delete();
        for (int i = 0; i < 5; i++) begin
            bus.data_in = 8'(i + 1);
            bus.wren_in = 1'b1;
            check($sformatf("b2b_ready_%0d", i), 32'(bus.ready_out), 32'd1);
            step();
        end
        check("b2b_full", 32'(bus.ready_out), 32'd0);
        bus.data_in = 8'h66;
        step();
        bus.wren_in = 1'b0;
        check("b2b_still_full", 32'(bus.ready_out), 32'd0);
        steps(397 + 12);
        for (int i = 0; i < 5; i++) check_frame($sformatf("b2b_f%0d", i), 2 + 80 * i, 8'(i + 1));
        count_high("b2b_no_sixth", 402, 414);
        check("b2b_ready_end", 32'(bus.ready_out), 32'd1);

        // RX 0x3C, valid rises the cycle after the stop-bit sample, then pop
        valq.delete();
        send_frame(8'h3C, 1'b1);
        check("rx_valid_before", 32'(valq[77]), 32'd0);
        check("rx_valid_edge",   32'(valq[78]), 32'd1);
        check("rx_data",         32'(bus.data_out), 32'h3C);
        bus.rden_in = 1'b1;
        step();
        bus.rden_in = 1'b0;
        check("rx_pop_valid", 32'(bus.valid_out), 32'd0);
        check("rx_pop_data",  32'(bus.data_out),  32'd0);

        // RX overrun: five frames into a four-entry FIFO
        for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 1'b1);
        steps(4);
        check("ovr_flag",  32'(rx_overrun_out),   32'd1);
        check("ovr_ferr",  32'(rx_frame_err_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovr_valid_%0d", i), 32'(bus.valid_out), 32'd1);
            check($sformatf("ovr_data_%0d", i),  32'(bus.data_out),  32'(8'h10 + i));
            bus.rden_in = 1'b1;
            step();
            bus.rden_in = 1'b0;
        end
        check("ovr_empty", 32'(bus.valid_out), 32'd0);

        // RX errors: short glitch, then a frame with its stop bit low
        do_reset();
        check("err_ovr_cleared", 32'(rx_overrun_out), 32'd0);
        uart_rx = 1'b0;
        steps(2);
        uart_rx = 1'b1;
        steps(30);
        check("glitch_valid", 32'(bus.valid_out),    32'd0);
        check("glitch_ovr",   32'(rx_overrun_out),   32'd0);
        check("glitch_ferr",  32'(rx_frame_err_out), 32'd0);
        send_frame(8'h55, 1'b0);
        steps(30);
        check("ferr_valid", 32'(bus.valid_out),    32'd0);
        check("ferr_flag",  32'(rx_frame_err_out), 32'd1);
        check("ferr_ovr",   32'(rx_overrun_out),   32'd0);

        // Reset during the data bits of 0xFF and of 0x00
        bus.data_in = 8'hFF;
        bus.wren_in = 1'b1;
        step();
        bus.wren_in = 1'b0;
        steps(30);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstff_tx",    32'(uart_tx),          32'd1);
        check("rstff_ready", 32'(bus.ready_out),    32'd1);
        check("rstff_ferr",  32'(rx_frame_err_out), 32'd0);
        check("rstff_ovr",   32'(rx_overrun_out),   32'd0);
        txq.delete();
        steps(100);
        count_high("rstff_quiet", 0, 100);

        bus.data_in = 8'h00;
        bus.wren_in = 1'b1;
        step();
        bus.wren_in = 1'b0;
        steps(30);
        check("rst00_tx_low", 32'(uart_tx), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst00_tx", 32'(uart_tx), 32'd1);
        txq.delete();
        steps(100);
        count_high("rst00_quiet", 0, 100);

        // Reset in the middle of an RX frame discards the partial byte
        uart_rx = 1'b0;
        steps(8);
        uart_rx = 1'b1;
        steps(24);
        reset = 1'b1;
        step();
        reset = 1'b0;
        uart_rx = 1'b1;
        steps(100);
        check("rxrst_valid", 32'(bus.valid_out),    32'd0);
        check("rxrst_ferr",  32'(rx_frame_err_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
